// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready on both sides.
// Result is one bit wider than the operands, so it cannot overflow. A tag travels with each beat.
`timescale 1ns/1ps
module sm_addsub_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int MW = DATA_WIDTH - 1;

  logic [MW-1:0]         mag_a, mag_b;
  logic                  sign_a, sign_b_eff, a_gt_b, b_gt_a;
  logic                  s2_load, s1_load, in_fire;

  logic                  s1_valid_q;
  logic                  s1_add_q, s1_add_d;
  logic                  s1_sign_q, s1_sign_d;
  logic [MW-1:0]         s1_big_q, s1_big_d;
  logic [MW-1:0]         s1_small_q, s1_small_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] s2_mag_d;
  logic [DATA_WIDTH:0]   out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q;

  // A zero magnitude always carries a + sign, which folds -0 into +0.
  assign mag_a      = in_a[MW-1:0];
  assign mag_b      = in_b[MW-1:0];
  assign sign_a     = in_a[DATA_WIDTH-1] & (|mag_a);
  assign sign_b_eff = (in_b[DATA_WIDTH-1] ^ in_sub) & (|mag_b);
  assign a_gt_b     = mag_a > mag_b;
  assign b_gt_a     = mag_b > mag_a;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && s1_load;

  always_comb begin
    s1_add_d   = (sign_a == sign_b_eff);
    s1_big_d   = a_gt_b ? mag_a : mag_b;
    s1_small_d = a_gt_b ? mag_b : mag_a;
    if (s1_add_d)    s1_sign_d = sign_a;
    else if (a_gt_b) s1_sign_d = sign_a;
    else if (b_gt_a) s1_sign_d = sign_b_eff;
    else             s1_sign_d = 1'b0;
  end

  // big >= small is guaranteed by stage 1, so the subtraction never wraps.
  always_comb begin
    s2_mag_d   = s1_add_q ? ({1'b0, s1_big_q} + {1'b0, s1_small_q})
                          : {1'b0, s1_big_q - s1_small_q};
    out_data_d = {s1_sign_q & (|s2_mag_d), s2_mag_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_add_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (s1_load) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_add_q   <= s1_add_d;
        s1_sign_q  <= s1_sign_d;
        s1_big_q   <= s1_big_d;
        s1_small_q <= s1_small_d;
        s1_tag_q   <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        out_tag_q  <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Scoreboard bench for sm_addsub_pipe: directed vectors, backpressure, mid-flight reset
// and a long random run against an integer model.
`timescale 1ns/1ps
module tb_sm_addsub_pipe;
  localparam int DW     = 8;
  localparam int TW     = 4;
  localparam int N_RAND = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sub = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW:0]   out_data;
  logic [TW-1:0] out_tag;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int cyc = 0;
  int last_out_cyc = 0;
  int acc_cyc = 0;

  logic [TW+DW:0] exp_q[$];
  logic [TW+DW:0] pend = '0;
  bit             hold_v = 1'b0;
  logic [DW:0]    hold_d = '0;
  logic [TW-1:0]  hold_t = '0;

  sm_addsub_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors: a, b, sub, hand-computed result.
  logic [DW-1:0] dir_a   [13] = '{8'h05, 8'h05, 8'h05, 8'hFF, 8'h7F, 8'h03, 8'h80,
                                  8'h80, 8'h83, 8'h0A, 8'h7F, 8'h85, 8'h00};
  logic [DW-1:0] dir_b   [13] = '{8'h03, 8'h87, 8'h87, 8'hFF, 8'h7F, 8'h83, 8'h80,
                                  8'h00, 8'h05, 8'h14, 8'hFF, 8'h85, 8'h85};
  logic          dir_sub [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [DW:0]   dir_exp [13] = '{9'h008, 9'h102, 9'h00C, 9'h1FE, 9'h0FE, 9'h000, 9'h000,
                                  9'h000, 9'h108, 9'h10A, 9'h0FE, 9'h000, 9'h005};

  function automatic logic [DW:0] model(logic [DW-1:0] a, logic [DW-1:0] b, logic sub);
    int va, vb, r;
    va = a[DW-1] ? -int'(a[DW-2:0]) : int'(a[DW-2:0]);
    vb = b[DW-1] ? -int'(b[DW-2:0]) : int'(b[DW-2:0]);
    r  = sub ? va - vb : va + vb;
    return {(r < 0) ? 1'b1 : 1'b0, DW'((r < 0) ? -r : r)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  task automatic monitor();
    logic [TW+DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          n_cmp++;
          if (!(out_valid === 1'b1 && out_data === hold_d && out_tag === hold_t)) begin
            n_err++;
            $display("FAIL hold_stable: got v=%0b data=%h tag=%h expected v=1 data=%h tag=%h",
                     out_valid, out_data, out_tag, hold_d, hold_t);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          n_out++;
          last_out_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got data=%h tag=%h with empty scoreboard", out_data, out_tag);
          end else begin
            e = exp_q.pop_front();
            if ({out_tag, out_data} !== e) begin
              n_err++;
              $display("FAIL result: got tag=%h data=%h expected tag=%h data=%h",
                       out_tag, out_data, e[TW+DW:DW+1], e[DW:0]);
            end else begin
              $display("out tag=%h data=%h ok", out_tag, out_data);
            end
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_t = out_tag;
      end
    end
  endtask

  task automatic step(output bit fired);
    @(negedge clk);
    fired = rst_n && in_valid && in_ready;
    if (fired) begin
      exp_q.push_back(pend);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [DW-1:0] a, logic [DW-1:0] b, logic sub, logic [TW-1:0] tag,
                       logic [DW:0] res);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
    pend     = {tag, res};
    in_valid = 1'b1;
  endtask

  task automatic send(logic [DW-1:0] a, logic [DW-1:0] b, logic sub, logic [TW-1:0] tag,
                      logic [DW:0] res);
    bit f;
    f = 1'b0;
    drive(a, b, sub, tag, res);
    for (int i = 0; i < 64; i++) begin
      step(f);
      if (f) break;
    end
    if (!f) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step(f);
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit f;
    int acc, n0, c0, sent, iter;
    logic [DW-1:0] ra, rb;
    logic          rs;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid_post", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);

    // Directed vectors; first one alone to check latency, the rest back to back
    out_ready = 1'b1;
    send(dir_a[0], dir_b[0], dir_sub[0], 4'd1, dir_exp[0]);
    repeat (3) step(f);
    chk("latency", last_out_cyc - acc_cyc, 2);
    c0 = cyc;
    for (int i = 1; i < 13; i++) send(dir_a[i], dir_b[i], dir_sub[i], TW'(i), dir_exp[i]);
    chk("throughput", cyc - c0, 12);
    drain();

    // Backpressure: consumer stalled, four beats offered (a=t+1, b=+1 -> t+2)
    out_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 4; t++) begin
      drive(DW'(acc + 1), 8'h01, 1'b0, TW'(acc), (DW + 1)'(acc + 2));
      if (t == 2) chk("bp_in_ready_low", in_ready, 0);
      step(f);
      if (f) acc++;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 9'h002);
    chk("bp_out_tag", out_tag, 0);
    out_ready = 1'b1;
    n0 = n_out;
    for (int t = 0; t < 4; t++) begin
      if (acc < 4) drive(DW'(acc + 1), 8'h01, 1'b0, TW'(acc), (DW + 1)'(acc + 2));
      else in_valid = 1'b0;
      step(f);
      if (f) acc++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", acc, 4);
    chk("bp_one_per_cycle", n_out - n0, 4);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 4'hA, 9'h033);
    send(8'h05, 8'h01, 1'b1, 4'hB, 9'h004);
    chk("rstmid_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (8) step(f);
    chk("rstmid_no_output", n_out - n0, 0);
    chk("rstmid_out_data", out_data, 0);
    send(8'h81, 8'h81, 1'b0, 4'h5, 9'h102);
    drain();
    chk("rstmid_new_beat", n_out - n0, 1);

    // Random traffic against the integer model
    n0 = n_out;
    sent = 0;
    iter = 0;
    while (sent < N_RAND && iter < 60000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        ra = DW'($urandom);
        rb = DW'($urandom);
        rs = 1'($urandom);
        drive(ra, rb, rs, TW'(sent), model(ra, rb, rs));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(f);
      if (f) begin
        sent++;
        in_valid = 1'b0;
      end
      iter++;
    end
    in_valid = 1'b0;
    chk("rand_all_sent", sent, N_RAND);
    drain();
    chk("rand_no_loss_dup", n_out - n0, N_RAND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
